// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared receiver state encoding and bit-timing helper
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff: generic two-flop synchroniser with parameterised reset value
module uart_rx_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;
  // two back-to-back flops to settle the asynchronous input
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-cycle data and framing-error strobes
import uart_rx_pkg::*;
module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_rdy,
  output logic       frame_err,
  output logic       busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;
  logic             mid, full;
  uart_rx_sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i(clk_in),
    .rst_i(reset),
    .d_i  (rx_in),
    .q_o  (rx_s)
  );
  assign mid  = timer_q == MID;
  assign full = timer_q == FULL;
  // state, timing and output registers
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  // next state: timer is cleared on every transition and sample point so it never wraps
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (mid) begin
        timer_d = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (full) begin
        timer_d = '0;
        shift_d = {rx_s, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (full) begin
        timer_d = '0;
        state_d = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        timer_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs: stop-bit sample decides between a good byte and a framing error
  always_comb begin
    rdy_d  = state_q == STOP && full && rx_s;
    ferr_d = state_q == STOP && full && !rx_s;
    data_d = rdy_d ? shift_q : data_q;
  end
  assign data_out  = data_q;
  assign data_rdy  = rdy_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_rdy, frame_err, busy;
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, rdy_cyc = 0;
  int rdy_cnt = 0, ferr_cnt = 0;
  logic [8:0] sb[$];
  logic [8:0] e;
  logic [7:0] last_good = 8'h00;
  logic prev_rdy = 1'b0, prev_ferr = 1'b0;

  uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk_in   (clk),
    .reset    (reset),
    .rx_in    (rx),
    .data_out (data_out),
    .data_rdy (data_rdy),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic exp_byte(input logic [7:0] b);
    sb.push_back({1'b0, b});
    last_good = b;
  endtask

  task automatic exp_ferr();
    sb.push_back({1'b1, last_good});
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string n);
    chk({n, "_data_out"}, data_out, 8'h00);
    chk({n, "_data_rdy"}, data_rdy, 1'b0);
    chk({n, "_frame_err"}, frame_err, 1'b0);
    chk({n, "_busy"}, busy, 1'b0);
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset && (data_rdy || frame_err)) begin
      chk("strobe_exclusive", data_rdy && frame_err, 1'b0);
      chk("strobe_width", data_rdy ? prev_rdy : prev_ferr, 1'b0);
      if (sb.size() == 0) chk("unexpected_strobe", 1'b1, 1'b0);
      else begin
        e = sb.pop_front();
        chk("strobe_kind", frame_err, e[8]);
        chk("data_out", data_out, e[7:0]);
      end
      if (data_rdy) begin
        rdy_cnt++;
        rdy_cyc = cyc;
      end else ferr_cnt++;
    end
    prev_rdy = data_rdy;
    prev_ferr = frame_err;
  end

  initial begin
    int r0, f0, n;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    // 1: single frame and latency
    r0 = rdy_cnt;
    exp_byte(8'h63);
    send(8'h63, 1'b1);
    chk("t1_latency_in_range", (rdy_cyc - start_cyc >= 154) && (rdy_cyc - start_cyc <= 158), 1'b1);
    repeat (4) @(negedge clk);
    chk("t1_rdy_count", rdy_cnt - r0, 1);
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_sb_empty", sb.size(), 0);
    // 2: short glitch rejected
    r0 = rdy_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t2_busy_fell", busy, 1'b0);
    repeat (200) @(negedge clk);
    chk("t2_no_rdy", rdy_cnt - r0, 0);
    chk("t2_no_ferr", ferr_cnt - f0, 0);
    chk("t2_data_kept", data_out, 8'h63);
    // 3: framing error, held-low line, then recovery
    r0 = rdy_cnt;
    f0 = ferr_cnt;
    exp_ferr();
    send(8'hA5, 1'b0);
    repeat (48) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    chk("t3_one_ferr", ferr_cnt - f0, 1);
    chk("t3_no_rdy_yet", rdy_cnt - r0, 0);
    chk("t3_data_kept", data_out, 8'h63);
    exp_byte(8'h12);
    send(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    chk("t3_one_rdy", rdy_cnt - r0, 1);
    chk("t3_ferr_total", ferr_cnt - f0, 1);
    chk("t3_sb_empty", sb.size(), 0);
    // 4: back-to-back frames
    r0 = rdy_cnt;
    f0 = ferr_cnt;
    exp_byte(8'h00);
    exp_byte(8'hFF);
    exp_byte(8'h80);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h80, 1'b1);
    repeat (20) @(negedge clk);
    chk("t4_three_rdy", rdy_cnt - r0, 3);
    chk("t4_no_ferr", ferr_cnt - f0, 0);
    chk("t4_sb_empty", sb.size(), 0);
    // 5: reset during data bit 4, then a clean frame
    r0 = rdy_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (72) @(negedge clk);
    chk("t5_busy_midframe", busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs("t5_in_reset");
    reset = 1'b0;
    repeat (32) @(negedge clk);
    last_good = 8'h00;
    chk("t5_no_rdy_aborted", rdy_cnt - r0, 0);
    exp_byte(8'h3C);
    send(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    chk("t5_one_rdy", rdy_cnt - r0, 1);
    chk("t5_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
